// File: rtl/da2_pkg.sv
// ============================================================================
// da2_pkg : shared types and constants for the PmodDA2 serial transmitter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package da2_pkg;

  localparam int FRAME_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ACK   = 2'd3
  } da2_state_e;

  // DAC121S101 power-down modes (PD1..PD0)
  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  function automatic logic [FRAME_W-1:0] da2_frame(input logic [1:0]  cmd,
                                                   input logic [11:0] data);
    return {2'b00, cmd, data};
  endfunction

endpackage

`default_nettype wire

// File: rtl/da2_serial_tx_if.sv
// ============================================================================
// da2_serial_tx_if : generator handshake plus DAC pin bundle
// Optional second channel under DA2_DUAL_EN
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface da2_serial_tx_if;

  logic        dacdav;
  logic [1:0]  daccmd;
  logic [11:0] dacdata;
  logic        davdac;
  logic        dacsync;
  logic        dacsck;
  logic        dacout;

`ifdef DA2_DUAL_EN
  logic [1:0]  daccmd2;
  logic [11:0] dacdata2;
  logic        dacout2;

  modport master (output dacdav, daccmd, dacdata, daccmd2, dacdata2,
                  input  davdac, dacsync, dacsck, dacout, dacout2);
  modport slave  (input  dacdav, daccmd, dacdata, daccmd2, dacdata2,
                  output davdac, dacsync, dacsck, dacout, dacout2);
`else
  modport master (output dacdav, daccmd, dacdata,
                  input  davdac, dacsync, dacsck, dacout);
  modport slave  (input  dacdav, daccmd, dacdata,
                  output davdac, dacsync, dacsck, dacout);
`endif

endinterface

`default_nettype wire

// File: rtl/da2_sckgen.sv
// ============================================================================
// da2_sckgen : SCLK divider, toggles every SCK_HALF cycles while enabled
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module da2_sckgen #(
  parameter int SCK_HALF = 1
) (
  input  wire logic clk_i,
  input  wire logic rst_ni,
  input  wire logic en_i,
  output logic      sck_o,
  output logic      fall_o,
  output logic      rise_o
);

  localparam int CW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          tick;

  assign tick = en_i && (cnt_q == CW'(SCK_HALF - 1));

  // Disabled divider parks SCLK high with the phase counter cleared
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b1;
    end else if (tick) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sck_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o  = sck_q;
  assign fall_o = tick & sck_q;
  assign rise_o = tick & ~sck_q;

endmodule

`default_nettype wire

// File: rtl/da2_serial_tx.sv
// ============================================================================
// da2_serial_tx : dav/ack-fed SYNC-framed serial transmitter for PmodDA2
// Optional lockstep channel B under DA2_DUAL_EN
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module da2_serial_tx
  import da2_pkg::*;
#(
  parameter int SCK_HALF  = 1,
  parameter int SYNC_HOLD = 2
) (
  input wire logic       dacclk,
  input wire logic       dacrstn,
  da2_serial_tx_if.slave bus
);

  localparam int HW = (SYNC_HOLD > 1) ? $clog2(SYNC_HOLD) : 1;

  da2_state_e         state_q;
  logic [FRAME_W-1:0] shreg_q;
  logic [FRAME_W-1:0] frame_d;
  logic [4:0]         fall_cnt_q;
  logic [HW-1:0]      hold_cnt_q;
  logic               sync_q;
  logic               out_q;
  logic               ack_q;
  logic               sck;
  logic               sck_fall;
  logic               sck_rise;

`ifdef DA2_DUAL_EN
  logic [FRAME_W-1:0] shreg2_q;
  logic [FRAME_W-1:0] frame2_d;
  logic               out2_q;
  assign frame2_d    = da2_frame(bus.daccmd2, bus.dacdata2);
  assign bus.dacout2 = out2_q;
`endif

  assign frame_d = da2_frame(bus.daccmd, bus.dacdata);

  da2_sckgen #(.SCK_HALF(SCK_HALF)) u_sckgen (
    .clk_i  (dacclk),
    .rst_ni (dacrstn),
    .en_i   (state_q == ST_SHIFT),
    .sck_o  (sck),
    .fall_o (sck_fall),
    .rise_o (sck_rise)
  );

  always_ff @(posedge dacclk or negedge dacrstn) begin
    if (!dacrstn) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      fall_cnt_q <= '0;
      hold_cnt_q <= '0;
      sync_q     <= 1'b1;
      out_q      <= 1'b0;
      ack_q      <= 1'b0;
`ifdef DA2_DUAL_EN
      shreg2_q   <= '0;
      out2_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.dacdav) begin
            shreg_q <= frame_d;
            out_q   <= frame_d[FRAME_W-1];
            sync_q  <= 1'b0;
            state_q <= ST_SHIFT;
`ifdef DA2_DUAL_EN
            shreg2_q <= frame2_d;
            out2_q   <= frame2_d[FRAME_W-1];
`endif
          end
        end
        ST_SHIFT: begin
          if (sck_fall) begin
            fall_cnt_q <= fall_cnt_q + 5'd1;
          end
          // The rise after the last fall closes the frame; earlier rises advance data
          if (sck_rise) begin
            if (fall_cnt_q == 5'(FRAME_W)) begin
              sync_q  <= 1'b1;
              out_q   <= 1'b0;
              state_q <= ST_HOLD;
`ifdef DA2_DUAL_EN
              out2_q  <= 1'b0;
`endif
            end else begin
              shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
              out_q   <= shreg_q[FRAME_W-2];
`ifdef DA2_DUAL_EN
              shreg2_q <= {shreg2_q[FRAME_W-2:0], 1'b0};
              out2_q   <= shreg2_q[FRAME_W-2];
`endif
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == HW'(SYNC_HOLD - 1)) begin
            hold_cnt_q <= '0;
            fall_cnt_q <= '0;
            ack_q      <= 1'b1;
            state_q    <= ST_ACK;
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
        ST_ACK: begin
          if (!bus.dacdav) begin
            ack_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.dacsync = sync_q;
  assign bus.dacsck  = sck;
  assign bus.dacout  = out_q;
  assign bus.davdac  = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_da2_serial_tx.sv
// ============================================================================
// tb_da2_serial_tx : scoreboard bench, DUT A default timing, DUT B SCK_HALF=3
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_da2_serial_tx;
  import da2_pkg::*;

  typedef struct {
    logic [15:0] w;
    logic [15:0] w2;
    logic [13:0] ch2;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q0[$];
  exp_t q1[$];

  da2_serial_tx_if bus_a();
  da2_serial_tx_if bus_b();

  da2_serial_tx dut_a (.dacclk(clk), .dacrstn(rstn), .bus(bus_a));
  da2_serial_tx #(.SCK_HALF(3), .SYNC_HOLD(2)) dut_b (.dacclk(clk), .dacrstn(rstn), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic get_sync(input int d);
    return (d != 0) ? bus_b.dacsync : bus_a.dacsync;
  endfunction
  function automatic logic get_sck(input int d);
    return (d != 0) ? bus_b.dacsck : bus_a.dacsck;
  endfunction
  function automatic logic get_out(input int d);
    return (d != 0) ? bus_b.dacout : bus_a.dacout;
  endfunction
  function automatic logic get_ack(input int d);
    return (d != 0) ? bus_b.davdac : bus_a.davdac;
  endfunction
  function automatic logic get_out2(input int d);
`ifdef DA2_DUAL_EN
    return (d != 0) ? bus_b.dacout2 : bus_a.dacout2;
`else
    return (d != 0) ? 1'b0 : 1'b0;
`endif
  endfunction

  task automatic drive(input int d, input logic dav, input logic [13:0] ch1, input logic [13:0] ch2);
    if (d == 0) begin
      bus_a.dacdav = dav; bus_a.daccmd = ch1[13:12]; bus_a.dacdata = ch1[11:0];
`ifdef DA2_DUAL_EN
      bus_a.daccmd2 = ch2[13:12]; bus_a.dacdata2 = ch2[11:0];
`endif
    end else begin
      bus_b.dacdav = dav; bus_b.daccmd = ch1[13:12]; bus_b.dacdata = ch1[11:0];
`ifdef DA2_DUAL_EN
      bus_b.daccmd2 = ch2[13:12]; bus_b.dacdata2 = ch2[11:0];
`endif
    end
  endtask

  task automatic chk_idle(input int d, input string name);
    chk(name, {28'd0, get_sync(d), get_sck(d), get_out(d), get_ack(d)}, 32'b1100);
`ifdef DA2_DUAL_EN
    chk({name, "_out2"}, {31'd0, get_out2(d)}, 32'd0);
`endif
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rstn = 1'b0;
    drive(0, 1'b0, 14'd0, 14'd0);
    drive(1, 1'b0, 14'd0, 14'd0);
    @(posedge clk); #1;
    chk_idle(0, "midframe_reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // mode 0: normal, 1: data changes mid-frame, 2: dav dropped early, 3: reset mid-frame
  task automatic send(input int d, input logic [13:0] ch1, input logic [13:0] ch2,
                      input logic [15:0] w1, input logic [15:0] w2, input int mode);
    exp_t e;
    int   n, h, hi;
    bit   seen;
    h = (d != 0) ? 3 : 1;
    e.w = w1; e.w2 = w2; e.ch2 = ch2;
    if (mode != 3) begin
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    drive(d, 1'b1, ch1, ch2);
    seen = 0;
    for (int i = 1; i <= 4 && !seen; i++) begin
      @(posedge clk); #1;
      if (!get_sync(d)) begin
        seen = 1;
        chk("capture_latency", i, 1);
      end
    end
    chk("capture_seen", {31'd0, seen}, 1);
    if (!seen) return;
    n = 0; seen = 0;
    while (!seen && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (mode == 1 && n == 5) drive(d, 1'b1, {ch1[13:12], 12'h000}, {ch2[13:12], 12'h000});
      if (mode == 2 && n == 5) drive(d, 1'b0, ch1, ch2);
      if (mode == 3 && n == 14) begin
        reset_pulse();
        return;
      end
      if (get_ack(d)) seen = 1;
    end
    chk("ack_seen", {31'd0, seen}, 1);
    chk("ack_latency", n, 32 * h + 2);
    hi = 1;
    if (mode != 2) begin
      repeat (2) begin
        @(posedge clk); #1;
        if (get_ack(d)) hi++;
      end
    end
    drive(d, 1'b0, ch1, ch2);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (get_ack(d)) hi++;
      else break;
    end
    chk("ack_width", hi, (mode == 2) ? 1 : 3);
  endtask

  // Monitor: shifts DIN in at each SCLK fall, scores the word when SYNC rises
  logic [15:0] mbits[2];
  logic [15:0] mbits2[2];
  int          mnb[2];
  int          mslen[2];
  int          mlast[2];
  logic        psck[2];
  logic        psync[2];

  always @(posedge clk) begin : mon
    logic s, k;
    int   h;
    exp_t e;
    bit   got;
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      s = get_sync(d);
      k = get_sck(d);
      h = (d != 0) ? 3 : 1;
      if (!rstn) begin
        mnb[d] = 0;
        mslen[d] = 0;
      end else begin
        if (!s) mslen[d]++;
        if (psck[d] && !k && !s) begin
          if (mnb[d] > 0) chk("sck_period", cyc - mlast[d], 2 * h);
          mlast[d]  = cyc;
          mbits[d]  = {mbits[d][14:0], get_out(d)};
          mbits2[d] = {mbits2[d][14:0], get_out2(d)};
          mnb[d]++;
        end
        if (!psync[d] && s) begin
          got = 0;
          if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1; end
          if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1; end
          if (!got) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: dut %0d got %0h want none", d, mbits[d]);
          end else begin
            chk("frame_word", {16'd0, mbits[d]}, {16'd0, e.w});
            chk("fall_count", mnb[d], 16);
            chk("sync_low_len", mslen[d], 32 * h);
`ifdef DA2_DUAL_EN
            chk("frame_word2", {16'd0, mbits2[d]}, {16'd0, e.w2});
`endif
          end
          mnb[d] = 0;
          mslen[d] = 0;
        end
      end
      psck[d]  = k;
      psync[d] = s;
    end
  end

  initial begin
    rstn = 1'b0;
    drive(0, 1'b0, 14'd0, 14'd0);
    drive(1, 1'b0, 14'd0, 14'd0);
    repeat (3) @(posedge clk);
    #1;
    chk_idle(0, "reset_state_a");
    chk_idle(1, "reset_state_b");
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send(0, {PD_NORMAL, 12'hA5C}, {PD_NORMAL, 12'h123}, 16'h0A5C, 16'h0123, 0);
    send(0, {PD_NORMAL, 12'h123}, {PD_NORMAL, 12'hABC}, 16'h0123, 16'h0ABC, 0);
    // ramp across the 4095 -> 0 wrap
    send(0, {PD_1K, 12'hFFE}, {PD_100K, 12'h000}, 16'h1FFE, 16'h2000, 0);
    send(0, {PD_1K, 12'hFFF}, {PD_100K, 12'h001}, 16'h1FFF, 16'h2001, 0);
    send(0, {PD_1K, 12'h000}, {PD_100K, 12'h002}, 16'h1000, 16'h2002, 0);
    send(0, {PD_1K, 12'h001}, {PD_100K, 12'h003}, 16'h1001, 16'h2003, 0);
    send(0, {PD_100K, 12'h7E1}, {PD_HIZ, 12'h5A5}, 16'h27E1, 16'h35A5, 1);
    send(0, {PD_NORMAL, 12'h555}, {PD_NORMAL, 12'hAAA}, 16'h0555, 16'h0AAA, 2);
    send(0, {PD_HIZ, 12'hFFF}, {PD_HIZ, 12'hFFF}, 16'h3FFF, 16'h3FFF, 3);
    send(0, {PD_NORMAL, 12'h9C3}, {PD_1K, 12'h3C9}, 16'h09C3, 16'h13C9, 0);
    send(1, {PD_HIZ, 12'hFFF}, {PD_NORMAL, 12'h001}, 16'h3FFF, 16'h0001, 0);

    repeat (5) @(posedge clk);
    #2;
    chk("queue_drained", q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
